// File: rtl/msrv32_dmem_ctrl.sv
// msrv32_dmem_ctrl -- data-memory access controller for the msrv32 core.
//
// Takes one load/store request at a time, checks alignment, runs a single-beat
// address/data transaction on the data bus (with wait states), captures read
// data and the bus response, and presents them to the load unit.
//
// Handshake: a request is taken on a rising edge where req_valid_in=1 and
// req_ready_out=1 (IDLE only). The response is a one-cycle rsp_valid_out pulse;
// rsp_* fields then hold until the next response. On the bus, dmreq is a
// one-cycle address strobe; the data phase ends on the first edge with
// data_hready_in=1, and hresp/dmdata are sampled with it.
//
// Ports:
//   clock/reset     : ms_riscv32_mp_clk_in, ms_riscv32_mp_rst_in (sync, active-high)
//   request side    : req_valid_in, req_write_in, req_addr_in, req_wdata_in,
//                     req_size_in, req_unsigned_in, req_ready_out
//   data bus        : ms_riscv32_mp_dmaddr_out, _dmdata_out, _dmreq_out, _dmwr_out,
//                     _dmwr_mask_out, _data_hready_in, _data_hresp_in, _dmdata_in
//   response side   : rsp_valid_out, rsp_rdata_out, rsp_addr_lsb_out, rsp_size_out,
//                     rsp_unsigned_out, rsp_bus_err_out, rsp_misaligned_out,
//                     rsp_timeout_out
//   pipeline        : stall_out
//   debug           : dbg_state_out (FSM state: 0 IDLE, 1 ADDR, 2 DATA, 3 RESP)
//
// Optional feature: define MSRV32_DMEM_TIMEOUT_EN to bound the DATA phase at
// TIMEOUT_CYCLES wait states (1..255); without it DATA waits indefinitely.

module msrv32_dmem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        req_valid_in,
  input  logic        req_write_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  output logic        req_ready_out,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        ms_riscv32_mp_dmreq_out,
  output logic        ms_riscv32_mp_dmwr_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  input  logic        ms_riscv32_mp_data_hready_in,
  input  logic        ms_riscv32_mp_data_hresp_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  output logic        rsp_valid_out,
  output logic [31:0] rsp_rdata_out,
  output logic [1:0]  rsp_addr_lsb_out,
  output logic [1:0]  rsp_size_out,
  output logic        rsp_unsigned_out,
  output logic        rsp_bus_err_out,
  output logic        rsp_misaligned_out,
  output logic        rsp_timeout_out,
  output logic        stall_out,
  output logic [1:0]  dbg_state_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_write;
  logic [31:0] r_rdata;
  logic [1:0]  r_rsp_lsb;
  logic [1:0]  r_rsp_size;
  logic        r_rsp_unsigned;
  logic        r_rsp_bus_err;
  logic        r_rsp_misaligned;

  logic        w_req_misaligned;
  logic        w_to_hit;
  logic [3:0]  w_mask;
  logic [31:0] w_lane_data;

  // Alignment is judged on the incoming request so a fault skips the bus.
  always_comb begin
    w_req_misaligned = 1'b0;
    case (req_size_in)
      2'b00:   w_req_misaligned = 1'b0;
      2'b01:   w_req_misaligned = req_addr_in[0];
      default: w_req_misaligned = |req_addr_in[1:0];
    endcase
  end

  // Byte-lane enables and lane-replicated store data from the latched request.
  always_comb begin
    w_mask      = 4'b1111;
    w_lane_data = r_wdata;
    case (r_size)
      2'b00: begin
        w_mask      = 4'b0001 << r_addr[1:0];
        w_lane_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_mask      = 4'b0011 << {r_addr[1], 1'b0};
        w_lane_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_mask      = 4'b1111;
        w_lane_data = r_wdata;
      end
    endcase
  end

`ifdef MSRV32_DMEM_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_rsp_timeout;

  // Counts DATA cycles without hready; a completing hready takes priority
  // over the limit in the same cycle.
  assign w_to_hit = (r_state == S_DATA) && !ms_riscv32_mp_data_hready_in &&
                    (r_to_cnt == TIMEOUT_CYCLES[7:0]);

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_to_cnt <= 8'd0;
    end else if (r_state == S_ADDR) begin
      r_to_cnt <= 8'd0;
    end else if (r_state == S_DATA && !ms_riscv32_mp_data_hready_in) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end

  assign rsp_timeout_out = r_rsp_timeout;
`else
  logic [7:0] w_unused_to_limit;
  assign w_unused_to_limit = TIMEOUT_CYCLES[7:0];
  assign w_to_hit          = 1'b0;
  assign rsp_timeout_out   = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid_in) w_next = w_req_misaligned ? S_RESP : S_ADDR;
      S_ADDR: w_next = S_DATA;
      S_DATA: if (ms_riscv32_mp_data_hready_in || w_to_hit) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state          <= S_IDLE;
      r_addr           <= 32'd0;
      r_wdata          <= 32'd0;
      r_size           <= 2'd0;
      r_unsigned       <= 1'b0;
      r_write          <= 1'b0;
      r_rdata          <= 32'd0;
      r_rsp_lsb        <= 2'd0;
      r_rsp_size       <= 2'd0;
      r_rsp_unsigned   <= 1'b0;
      r_rsp_bus_err    <= 1'b0;
      r_rsp_misaligned <= 1'b0;
`ifdef MSRV32_DMEM_TIMEOUT_EN
      r_rsp_timeout    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid_in) begin
            r_addr     <= req_addr_in;
            r_wdata    <= req_wdata_in;
            r_size     <= req_size_in;
            r_unsigned <= req_unsigned_in;
            r_write    <= req_write_in;
            if (w_req_misaligned) begin
              r_rsp_lsb        <= req_addr_in[1:0];
              r_rsp_size       <= req_size_in;
              r_rsp_unsigned   <= req_unsigned_in;
              r_rsp_bus_err    <= 1'b0;
              r_rsp_misaligned <= 1'b1;
`ifdef MSRV32_DMEM_TIMEOUT_EN
              r_rsp_timeout    <= 1'b0;
`endif
            end
          end
        end
        S_DATA: begin
          if (ms_riscv32_mp_data_hready_in || w_to_hit) begin
            // Stores and timeouts leave the previously captured word in place.
            if (ms_riscv32_mp_data_hready_in && !r_write) r_rdata <= ms_riscv32_mp_dmdata_in;
            r_rsp_lsb        <= r_addr[1:0];
            r_rsp_size       <= r_size;
            r_rsp_unsigned   <= r_unsigned;
            r_rsp_bus_err    <= ms_riscv32_mp_data_hready_in ? ms_riscv32_mp_data_hresp_in : 1'b1;
            r_rsp_misaligned <= 1'b0;
`ifdef MSRV32_DMEM_TIMEOUT_EN
            r_rsp_timeout    <= !ms_riscv32_mp_data_hready_in;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_out               = (r_state == S_IDLE);
  assign stall_out                   = (r_state != S_IDLE);
  assign dbg_state_out               = r_state;
  assign ms_riscv32_mp_dmreq_out     = (r_state == S_ADDR);
  assign ms_riscv32_mp_dmwr_out      = r_write && (r_state == S_ADDR || r_state == S_DATA);
  assign ms_riscv32_mp_dmaddr_out    = {r_addr[31:2], 2'b00};
  assign ms_riscv32_mp_dmwr_mask_out = r_write ? w_mask : 4'b0000;
  assign ms_riscv32_mp_dmdata_out    = w_lane_data;
  assign rsp_valid_out               = (r_state == S_RESP);
  assign rsp_rdata_out               = r_rdata;
  assign rsp_addr_lsb_out            = r_rsp_lsb;
  assign rsp_size_out                = r_rsp_size;
  assign rsp_unsigned_out            = r_rsp_unsigned;
  assign rsp_bus_err_out             = r_rsp_bus_err;
  assign rsp_misaligned_out          = r_rsp_misaligned;

endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// Testbench for msrv32_dmem_ctrl: directed scenarios plus randomized
// transactions checked against a behavioural model of the controller.
module tb_msrv32_dmem_ctrl;

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 0;   // 0: no timeout limit
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        req_valid, req_write, req_unsigned, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [31:0] dmaddr, dmdata_o, dmdata_i;
  logic        dmreq, dmwr, hready, hresp;
  logic [3:0]  dmmask;
  logic        rsp_valid, rsp_uns, rsp_err, rsp_mis, rsp_to, stall;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_lsb, rsp_size, dbg_state;

  msrv32_dmem_ctrl #(.TIMEOUT_CYCLES((TB_TO > 0) ? TB_TO : 255)) dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .req_valid_in(req_valid), .req_write_in(req_write), .req_addr_in(req_addr),
    .req_wdata_in(req_wdata), .req_size_in(req_size), .req_unsigned_in(req_unsigned),
    .req_ready_out(req_ready),
    .ms_riscv32_mp_dmaddr_out(dmaddr), .ms_riscv32_mp_dmdata_out(dmdata_o),
    .ms_riscv32_mp_dmreq_out(dmreq), .ms_riscv32_mp_dmwr_out(dmwr),
    .ms_riscv32_mp_dmwr_mask_out(dmmask), .ms_riscv32_mp_data_hready_in(hready),
    .ms_riscv32_mp_data_hresp_in(hresp), .ms_riscv32_mp_dmdata_in(dmdata_i),
    .rsp_valid_out(rsp_valid), .rsp_rdata_out(rsp_rdata), .rsp_addr_lsb_out(rsp_lsb),
    .rsp_size_out(rsp_size), .rsp_unsigned_out(rsp_uns), .rsp_bus_err_out(rsp_err),
    .rsp_misaligned_out(rsp_mis), .rsp_timeout_out(rsp_to), .stall_out(stall),
    .dbg_state_out(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  // m_*: response fields the model says are currently presented.
  // h_*: snapshot of m_* before the current transaction (must hold until RESP).
  logic [31:0] m_rdata, h_rdata;
  logic [6:0]  m_flags, h_flags;   // {err, mis, to, lsb[1:0], size[1:0]}
  logic        m_uns, h_uns;
  logic [31:0] exp_addr, exp_data, exp_rdata;
  logic [3:0]  exp_mask;
  logic        exp_mis, exp_err, exp_to;
  int          exp_rsp_cyc;

  task automatic model_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, input int waits,
                           input logic resp, input logic [31:0] rdata);
    int nb, off;
    bit timed_out;
    h_rdata = m_rdata; h_flags = m_flags; h_uns = m_uns;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    exp_mis = (off % nb) != 0;
    exp_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nb) exp_mask[i] = 1'b1;
      exp_data[i*8 +: 8] = wdata[(i % nb)*8 +: 8];
    end
    if (!wr) exp_mask = 4'b0000;
    exp_addr  = addr - (addr % 4);
    timed_out = (TB_TO > 0) && (waits > TB_TO);
    exp_to    = !exp_mis && timed_out;
    exp_rsp_cyc = exp_mis ? 1 : (3 + (timed_out ? TB_TO : waits));
    exp_err   = exp_mis ? 1'b0 : (exp_to ? 1'b1 : resp);
    exp_rdata = (!exp_mis && !wr && !exp_to) ? rdata : m_rdata;
    m_rdata = exp_rdata;
    m_flags = {exp_err, exp_mis, exp_to, 2'(off), size};
    m_uns   = uns;
  endtask

  // ---------------- driver / bus responder ----------------
  int          obs_req_cyc, obs_rsp_cyc, obs_req_cnt, obs_stall_cnt;
  bit          obs_bus_hold_ok, obs_rsp_hold_ok, obs_ready_ok;
  logic [31:0] obs_addr, obs_data, obs_rdata;
  logic [3:0]  obs_mask;
  logic        obs_wr, obs_uns;
  logic [6:0]  obs_flags;

  // Drives one request; cycle k counts clocks after the accepting edge.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int waits,
                        input logic resp, input logic [31:0] rdata);
    obs_req_cyc = -1; obs_rsp_cyc = -1; obs_req_cnt = 0; obs_stall_cnt = 0;
    obs_bus_hold_ok = 1; obs_rsp_hold_ok = 1; obs_ready_ok = 1;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    hready = 1'(($urandom_range(0, 1))); hresp = 1'($urandom_range(0, 1)); dmdata_i = $urandom();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_write = 1'($urandom_range(0, 1)); req_addr = $urandom();
        req_wdata = $urandom(); req_size = 2'($urandom_range(0, 3)); req_unsigned = ~uns;
      end
      if (stall) obs_stall_cnt++;
      if (req_ready !== ~stall) obs_ready_ok = 0;
      if (dmreq) begin
        obs_req_cnt++; obs_req_cyc = k;
        obs_addr = dmaddr; obs_data = dmdata_o; obs_mask = dmmask; obs_wr = dmwr;
      end else if (obs_req_cyc > 0 && !rsp_valid) begin
        if (dmaddr !== obs_addr || dmdata_o !== obs_data || dmmask !== obs_mask || dmwr !== obs_wr)
          obs_bus_hold_ok = 0;
      end
      if (!rsp_valid) begin
        if (rsp_rdata !== h_rdata || {rsp_err, rsp_mis, rsp_to, rsp_lsb, rsp_size} !== h_flags ||
            rsp_uns !== h_uns)
          obs_rsp_hold_ok = 0;
      end else begin
        obs_rsp_cyc = k; obs_rdata = rsp_rdata; obs_uns = rsp_uns;
        obs_flags = {rsp_err, rsp_mis, rsp_to, rsp_lsb, rsp_size};
      end
      if (obs_req_cyc > 0 && k > obs_req_cyc && obs_rsp_cyc < 0) begin
        if (k - obs_req_cyc - 1 == waits) begin
          hready = 1'b1; hresp = resp; dmdata_i = rdata;
        end else begin
          hready = 1'b0; hresp = 1'($urandom_range(0, 1)); dmdata_i = $urandom();
        end
      end else begin
        hready = 1'($urandom_range(0, 1)); hresp = 1'($urandom_range(0, 1)); dmdata_i = $urandom();
      end
      if (rsp_valid) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_size = 0;
    req_unsigned = 0; hready = 0; hresp = 0; dmdata_i = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, stall, dmreq, dmwr, rsp_valid} !== 5'b10000) begin
      n_fail++; $display("FAIL reset.ctrl got=%b exp=10000", {req_ready, stall, dmreq, dmwr, rsp_valid});
    end
    n_tests++;
    if ({dmaddr, dmdata_o, dmmask} !== 68'd0) begin
      n_fail++; $display("FAIL reset.bus got=%h exp=0", {dmaddr, dmdata_o, dmmask});
    end
    n_tests++;
    if ({rsp_rdata, rsp_lsb, rsp_size, rsp_uns, rsp_err, rsp_mis, rsp_to} !== 40'd0) begin
      n_fail++; $display("FAIL reset.rsp got=%h exp=0",
                         {rsp_rdata, rsp_lsb, rsp_size, rsp_uns, rsp_err, rsp_mis, rsp_to});
    end
    rst = 1'b0;
    m_rdata = 0; m_flags = 0; m_uns = 0;
  endtask

  task automatic test_word_load();
    model_txn(0, 32'h100, 32'h1234_5678, 2'b10, 0, 0, 0, 32'hDEAD_BEEF);
    do_txn   (0, 32'h100, 32'h1234_5678, 2'b10, 0, 0, 0, 32'hDEAD_BEEF);
    n_tests++;
    if (obs_req_cyc !== 1 || obs_req_cnt !== 1) begin
      n_fail++; $display("FAIL word_load.dmreq got=cyc%0d/cnt%0d exp=cyc1/cnt1", obs_req_cyc, obs_req_cnt);
    end
    n_tests++;
    if ({obs_addr, obs_mask, obs_wr} !== {32'h100, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL word_load.bus got=%h/%b/%b exp=100/0000/0", obs_addr, obs_mask, obs_wr);
    end
    n_tests++;
    if (obs_rsp_cyc !== 3 || obs_rdata !== 32'hDEAD_BEEF || obs_flags[6] !== 1'b0) begin
      n_fail++; $display("FAIL word_load.rsp got=cyc%0d/%h/err%b exp=cyc3/deadbeef/err0",
                         obs_rsp_cyc, obs_rdata, obs_flags[6]);
    end
  endtask

  task automatic test_byte_store();
    model_txn(1, 32'h203, 32'h0000_00A5, 2'b00, 0, 1, 0, 32'h5555_1111);
    do_txn   (1, 32'h203, 32'h0000_00A5, 2'b00, 0, 1, 0, 32'h5555_1111);
    n_tests++;
    if ({obs_addr, obs_mask, obs_data, obs_wr} !== {32'h200, 4'b1000, 32'hA5A5_A5A5, 1'b1}) begin
      n_fail++; $display("FAIL byte_store.bus got=%h/%b/%h/%b exp=200/1000/a5a5a5a5/1",
                         obs_addr, obs_mask, obs_data, obs_wr);
    end
    n_tests++;
    if (obs_rsp_cyc !== 4 || obs_rdata !== 32'hDEAD_BEEF || obs_bus_hold_ok !== 1'b1) begin
      n_fail++; $display("FAIL byte_store.rsp got=cyc%0d/%h/hold%b exp=cyc4/deadbeef/hold1",
                         obs_rsp_cyc, obs_rdata, obs_bus_hold_ok);
    end
  endtask

  task automatic test_misaligned();
    model_txn(0, 32'h101, 32'h0, 2'b01, 1, 0, 0, 32'h0BAD_0BAD);
    do_txn   (0, 32'h101, 32'h0, 2'b01, 1, 0, 0, 32'h0BAD_0BAD);
    n_tests++;
    if (obs_rsp_cyc !== 1 || obs_req_cnt !== 0 || obs_stall_cnt !== 1) begin
      n_fail++; $display("FAIL misaligned.timing got=rsp%0d/req%0d/stall%0d exp=rsp1/req0/stall1",
                         obs_rsp_cyc, obs_req_cnt, obs_stall_cnt);
    end
    n_tests++;
    if ({obs_flags, obs_uns, obs_rdata} !== {exp_err, exp_mis, exp_to, 2'b01, 2'b01, 1'b1, exp_rdata}) begin
      n_fail++; $display("FAIL misaligned.rsp got=%b/%b/%h exp=%b/1/%h", obs_flags, obs_uns, obs_rdata,
                         {exp_err, exp_mis, exp_to, 2'b01, 2'b01}, exp_rdata);
    end
  endtask

  task automatic test_wait_err();
    model_txn(0, 32'h400, 32'h0, 2'b10, 0, 3, 1, 32'hCAFE_F00D);
    do_txn   (0, 32'h400, 32'h0, 2'b10, 0, 3, 1, 32'hCAFE_F00D);
    n_tests++;
    if (obs_rsp_cyc !== 6 || obs_stall_cnt !== 6 || obs_ready_ok !== 1'b1) begin
      n_fail++; $display("FAIL wait_err.timing got=rsp%0d/stall%0d/rdy%b exp=rsp6/stall6/rdy1",
                         obs_rsp_cyc, obs_stall_cnt, obs_ready_ok);
    end
    n_tests++;
    if (obs_flags[6] !== 1'b1 || obs_rdata !== exp_rdata || obs_bus_hold_ok !== 1'b1) begin
      n_fail++; $display("FAIL wait_err.rsp got=err%b/%h/hold%b exp=err1/%h/hold1",
                         obs_flags[6], obs_rdata, obs_bus_hold_ok, exp_rdata);
    end
  endtask

  task automatic test_reset_in_data();
    bit quiet;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 32'h300; req_size = 2'b10; hready = 0;
    @(negedge clk);   // ADDR
    req_valid = 0;
    @(negedge clk);   // DATA
    rst = 1'b1; hready = 0;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({req_ready, stall, dmreq, rsp_valid} !== 4'b1000) begin
      n_fail++; $display("FAIL rst_data.ctrl got=%b exp=1000", {req_ready, stall, dmreq, rsp_valid});
    end
    n_tests++;
    if ({rsp_rdata, rsp_lsb, rsp_size, rsp_uns, rsp_err, rsp_mis, rsp_to} !== 40'd0) begin
      n_fail++; $display("FAIL rst_data.rsp got=%h exp=0",
                         {rsp_rdata, rsp_lsb, rsp_size, rsp_uns, rsp_err, rsp_mis, rsp_to});
    end
    quiet = 1;
    hready = 1; hresp = 1; dmdata_i = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || !req_ready || rsp_rdata !== 32'd0 || rsp_err) quiet = 0;
    end
    n_tests++;
    if (quiet !== 1'b1) begin
      n_fail++; $display("FAIL rst_data.late_hready got=%b exp=1", quiet);
    end
    m_rdata = 0; m_flags = 0; m_uns = 0;
  endtask

`ifdef MSRV32_DMEM_TIMEOUT_EN
  task automatic test_timeout();
    model_txn(0, 32'h500, 32'h0, 2'b10, 0, 1000, 0, 32'h1111_2222);
    do_txn   (0, 32'h500, 32'h0, 2'b10, 0, 1000, 0, 32'h1111_2222);
    n_tests++;
    if (obs_rsp_cyc !== 7 || obs_flags[6:4] !== 3'b101 || obs_rdata !== exp_rdata) begin
      n_fail++; $display("FAIL timeout got=rsp%0d/flags%b/%h exp=rsp7/101/%h",
                         obs_rsp_cyc, obs_flags[6:4], obs_rdata, exp_rdata);
    end
  endtask
`endif

  task automatic test_random();
    logic        wr, uns, resp;
    logic [31:0] addr, wdata, rdata, exp_w;
    logic [1:0]  size;
    int          waits;
    for (int t = 0; t < 60; t++) begin
      wr = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1)); resp = 1'($urandom_range(0, 1));
      addr = $urandom(); wdata = $urandom(); rdata = $urandom(); size = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
      waits = $urandom_range(0, 5);
      model_txn(wr, addr, wdata, size, uns, waits, resp, rdata);
      exp_q.push_back(exp_rdata);
      do_txn(wr, addr, wdata, size, uns, waits, resp, rdata);
      exp_w = exp_q.pop_front();
      n_tests++;
      if (obs_rsp_cyc !== exp_rsp_cyc || obs_req_cnt !== (exp_mis ? 0 : 1) ||
          obs_stall_cnt !== exp_rsp_cyc || obs_ready_ok !== 1'b1) begin
        n_fail++; $display("FAIL rand%0d.timing got=rsp%0d/req%0d/stall%0d exp=rsp%0d/req%0d/stall%0d",
                           t, obs_rsp_cyc, obs_req_cnt, obs_stall_cnt, exp_rsp_cyc, exp_mis ? 0 : 1, exp_rsp_cyc);
      end
      if (!exp_mis) begin
        n_tests++;
        if ({obs_addr, obs_mask, obs_data, obs_wr} !== {exp_addr, exp_mask, exp_data, wr} ||
            obs_bus_hold_ok !== 1'b1) begin
          n_fail++; $display("FAIL rand%0d.bus got=%h/%b/%h/%b exp=%h/%b/%h/%b", t, obs_addr, obs_mask,
                             obs_data, obs_wr, exp_addr, exp_mask, exp_data, wr);
        end
      end
      n_tests++;
      if (obs_rdata !== exp_w || obs_flags !== m_flags || obs_uns !== uns || obs_rsp_hold_ok !== 1'b1) begin
        n_fail++; $display("FAIL rand%0d.rsp got=%h/%b/%b/hold%b exp=%h/%b/%b/hold1", t, obs_rdata,
                           obs_flags, obs_uns, obs_rsp_hold_ok, exp_w, m_flags, uns);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_misaligned();
    test_wait_err();
    test_reset_in_data();
`ifdef MSRV32_DMEM_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
